// File: rtl/fir_pair_sequencer.sv
// Sequential front end for an external two-tap multiply-add stage: one FIR output per sample,
// computed as TAPS/2 issued operand pairs. Optional delay-line flush port: FIR_SEQ_FLUSH_EN.
module fir_pair_sequencer #(
  parameter int DATA_WIDTH  = 8,
  parameter int COEFF_WIDTH = 8,
  parameter int TAPS        = 8,
  parameter int ACC_WIDTH   = DATA_WIDTH + COEFF_WIDTH + $clog2(TAPS)
) (
  input  logic                            clk,
  input  logic                            reset,
`ifdef FIR_SEQ_FLUSH_EN
  input  logic                            flush,
`endif
  input  logic                            coeff_we,
  input  logic [$clog2(TAPS)-1:0]         coeff_addr,
  input  logic [COEFF_WIDTH-1:0]          coeff_wdata,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_WIDTH-1:0]           in_data,
  output logic                            pair_valid,
  output logic [DATA_WIDTH-1:0]           pair_data1,
  output logic [DATA_WIDTH-1:0]           pair_data2,
  output logic [COEFF_WIDTH-1:0]          pair_coeff1,
  output logic [COEFF_WIDTH-1:0]          pair_coeff2,
  input  logic [DATA_WIDTH+COEFF_WIDTH:0] pair_result,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [ACC_WIDTH-1:0]            out_data
);

  localparam int ADDR_W = $clog2(TAPS);
  localparam int PAIRS  = TAPS / 2;
  localparam int IDX_W  = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAIRS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_OUTPUT
  } state_t;

  state_t                 r_state;
  logic [DATA_WIDTH-1:0]  r_tap   [TAPS];
  logic [COEFF_WIDTH-1:0] r_coeff [TAPS];
  logic [ACC_WIDTH-1:0]   r_acc;
  logic [IDX_W-1:0]       r_idx;
  logic                   r_pair_valid;
  logic                   r_out_valid;

  logic                   w_flush;
  logic                   w_idle;
  logic                   w_coeff_wr;
  logic [ADDR_W-1:0]      w_lo;
  logic [ADDR_W-1:0]      w_hi;

  // Non-power-of-two TAPS leaves address codes with no coefficient behind them.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
    return (int'(a) < TAPS);
  endfunction

`ifdef FIR_SEQ_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  assign w_idle     = (r_state == S_IDLE);
  assign w_coeff_wr = w_idle && coeff_we && addr_in_range(coeff_addr);
  assign w_lo       = ADDR_W'({r_idx, 1'b0});
  assign w_hi       = w_lo + ADDR_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_acc        <= '0;
      r_idx        <= '0;
      r_pair_valid <= 1'b0;
      r_out_valid  <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        r_tap[i]   <= '0;
        r_coeff[i] <= '0;
      end
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_coeff_wr) begin
            r_coeff[coeff_addr] <= coeff_wdata;
          end
          // A flush beats a simultaneous sample; the sample stays pending.
          if (w_flush) begin
            for (int i = 0; i < TAPS; i++) begin
              r_tap[i] <= '0;
            end
          end else if (in_valid) begin
            r_tap[0] <= in_data;
            for (int i = 1; i < TAPS; i++) begin
              r_tap[i] <= r_tap[i-1];
            end
            r_acc        <= '0;
            r_idx        <= '0;
            r_pair_valid <= 1'b1;
            r_state      <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          r_acc <= r_acc + ACC_WIDTH'(pair_result);
          if (r_idx == IDX_LAST) begin
            r_pair_valid <= 1'b0;
            r_out_valid  <= 1'b1;
            r_state      <= S_OUTPUT;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end

        // Everything, the delay line included, holds until the result is taken.
        S_OUTPUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_pair_valid <= 1'b0;
          r_out_valid  <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready    = w_idle && !reset && !w_flush;
  assign pair_valid  = r_pair_valid;
  assign pair_data1  = r_pair_valid ? r_tap[w_lo]   : '0;
  assign pair_data2  = r_pair_valid ? r_tap[w_hi]   : '0;
  assign pair_coeff1 = r_pair_valid ? r_coeff[w_lo] : '0;
  assign pair_coeff2 = r_pair_valid ? r_coeff[w_hi] : '0;
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_valid ? r_acc : '0;

endmodule

// File: tb/tb_fir_pair_sequencer.sv
// Self-checking bench for fir_pair_sequencer: directed steps plus random samples and coefficients,
// compared against an array-based FIR reference model.
module tb_fir_pair_sequencer;

  localparam int DW   = 8;
  localparam int CW   = 8;
  localparam int TAPS = 8;
  localparam int P    = TAPS / 2;
  localparam int AW   = $clog2(TAPS);
  localparam int ACCW = DW + CW + $clog2(TAPS);
  localparam int RW   = DW + CW + 1;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            coeff_we = 1'b0;
  logic [AW-1:0]   coeff_addr = '0;
  logic [CW-1:0]   coeff_wdata = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [DW-1:0]   in_data = '0;
  logic            pair_valid;
  logic [DW-1:0]   pair_data1, pair_data2;
  logic [CW-1:0]   pair_coeff1, pair_coeff2;
  logic [RW-1:0]   pair_result;
  logic [RW-1:0]   w_prod1, w_prod2;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [ACCW-1:0] out_data;
`ifdef FIR_SEQ_FLUSH_EN
  logic            flush = 1'b0;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int hist [TAPS];
  int coef [TAPS];

  fir_pair_sequencer #(
    .DATA_WIDTH (DW),
    .COEFF_WIDTH(CW),
    .TAPS       (TAPS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
`ifdef FIR_SEQ_FLUSH_EN
    .flush      (flush),
`endif
    .coeff_we   (coeff_we),
    .coeff_addr (coeff_addr),
    .coeff_wdata(coeff_wdata),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .pair_valid (pair_valid),
    .pair_data1 (pair_data1),
    .pair_data2 (pair_data2),
    .pair_coeff1(pair_coeff1),
    .pair_coeff2(pair_coeff2),
    .pair_result(pair_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
  );

  // External two-tap stage: purely combinational d1*c1 + d2*c2.
  assign w_prod1     = RW'(pair_data1) * RW'(pair_coeff1);
  assign w_prod2     = RW'(pair_data2) * RW'(pair_coeff2);
  assign pair_result = w_prod1 + w_prod2;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_fir();
    int s = 0;
    for (int i = 0; i < TAPS; i++) s += hist[i] * coef[i];
    return s;
  endfunction

  task automatic model_clear_all();
    for (int i = 0; i < TAPS; i++) begin
      hist[i] = 0;
      coef[i] = 0;
    end
  endtask

  // Called just after a negedge with the DUT idle.
  task automatic write_coef(input int a, input int v);
    coeff_we    = 1'b1;
    coeff_addr  = AW'(a);
    coeff_wdata = CW'(v);
    @(negedge clk);
    coeff_we = 1'b0;
    coef[a]  = v;
  endtask

  // Called just after a negedge with the DUT idle; returns just after the negedge following
  // the output handshake. pend keeps the next sample (nd) waiting through OUTPUT.
  task automatic do_sample(input int d, input int hold, input bit pend, input int nd,
                           input bit mw_en, input int mw_a, input int mw_v);
    int exp_v;
    chk("in_ready_idle", 64'(in_ready), 64'(1));
    in_valid = 1'b1;
    in_data  = DW'(d);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = d;
    exp_v = model_fir();
    for (int k = 0; k < P; k++) begin
      chk("pair_valid", 64'(pair_valid), 64'(1));
      chk("pair_ops", 64'({pair_data1, pair_coeff1, pair_data2, pair_coeff2}),
          64'({DW'(hist[2*k]), CW'(coef[2*k]), DW'(hist[2*k+1]), CW'(coef[2*k+1])}));
      chk("in_ready_issue", 64'({in_ready, out_valid}), 64'(0));
      if (mw_en && k == 0) begin
        coeff_we    = 1'b1;
        coeff_addr  = AW'(mw_a);
        coeff_wdata = CW'(mw_v);
      end
      @(negedge clk);
      coeff_we = 1'b0;
    end
    chk("out_valid", 64'(out_valid), 64'(1));
    chk("out_data", 64'(out_data), 64'(exp_v));
    chk("pair_idle", 64'({pair_valid, pair_data1, pair_coeff1, pair_data2, pair_coeff2}), 64'(0));
    if (pend) begin
      in_valid = 1'b1;
      in_data  = DW'(nd);
    end
    for (int h = 0; h < hold; h++) begin
      coeff_we    = 1'b1;
      coeff_addr  = AW'($urandom_range(0, TAPS - 1));
      coeff_wdata = CW'($urandom_range(0, 255));
      @(negedge clk);
      chk("hold_valid", 64'({out_valid, in_ready}), 64'(2));
      chk("hold_data", 64'(out_data), 64'(exp_v));
    end
    coeff_we  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("after_hs", 64'({out_valid, out_data}), 64'(0));
  endtask

  // Reset during ISSUE (where=0) or OUTPUT (where=1).
  task automatic reset_mid(input int where);
    in_valid = 1'b1;
    in_data  = DW'(8'hA5);
    @(negedge clk);
    in_valid = 1'b0;
    repeat ((where == 0) ? 1 : P) @(negedge clk);
    chk("pre_reset_state", 64'({pair_valid, out_valid}), (where == 0) ? 64'(2) : 64'(1));
    reset = 1'b1;
    #1;
    chk("reset_pair", 64'({pair_valid, pair_data1, pair_coeff1, pair_data2, pair_coeff2}), 64'(0));
    chk("reset_out", 64'({out_valid, out_data}), 64'(0));
    chk("reset_in_ready", 64'(in_ready), 64'(0));
    model_clear_all();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("release_in_ready", 64'(in_ready), 64'(1));
  endtask

  initial begin
    int d, nd;
    model_clear_all();

    // Reset state
    repeat (2) @(negedge clk);
    chk("por_outputs", 64'({pair_valid, out_valid, out_data}), 64'(0));
    chk("por_in_ready", 64'(in_ready), 64'(0));
    reset = 1'b0;
    #1;
    chk("por_release", 64'(in_ready), 64'(1));
    @(negedge clk);

    // Impulse response through coefficients 1..8
    for (int i = 0; i < TAPS; i++) write_coef(i, i + 1);
    do_sample(1, 0, 1'b0, 0, 1'b0, 0, 0);
    for (int i = 0; i < TAPS; i++) do_sample(0, 0, 1'b0, 0, 1'b0, 0, 0);

    // Full scale: no wrap in the accumulator
    for (int i = 0; i < TAPS; i++) write_coef(i, 255);
    for (int i = 0; i < TAPS; i++) do_sample(255, 0, 1'b0, 0, 1'b0, 0, 0);

    // Backpressure with a pending sample and dropped coefficient writes
    d  = int'($urandom_range(1, 255));
    nd = int'($urandom_range(1, 255));
    do_sample(d, 5, 1'b1, nd, 1'b0, 0, 0);
    do_sample(nd, 0, 1'b0, 0, 1'b0, 0, 0);

    // Coefficient write during ISSUE is dropped; the same write in IDLE lands
    do_sample(int'($urandom_range(1, 255)), 0, 1'b0, 0, 1'b1, 7, 0);
    do_sample(int'($urandom_range(1, 255)), 0, 1'b0, 0, 1'b0, 0, 0);
    write_coef(7, 0);
    do_sample(int'($urandom_range(1, 255)), 1, 1'b0, 0, 1'b0, 0, 0);

    // Random traffic
    for (int n = 0; n < 16; n++) begin
      if ($urandom_range(0, 1) == 1)
        write_coef(int'($urandom_range(0, TAPS - 1)), int'($urandom_range(0, 255)));
      do_sample(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)), 1'b0, 0, 1'b0, 0, 0);
    end

    // Reset mid-ISSUE and mid-OUTPUT discard the result and clear all state
    reset_mid(0);
    @(negedge clk);
    reset_mid(1);
    @(negedge clk);
    for (int i = 0; i < TAPS; i++) write_coef(i, int'($urandom_range(1, 255)));
    for (int n = 0; n < 4; n++) do_sample(int'($urandom_range(0, 255)), 0, 1'b0, 0, 1'b0, 0, 0);

`ifdef FIR_SEQ_FLUSH_EN
    // Flush wins over a simultaneous sample, then a zero sample yields zero
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = DW'(8'h55);
    #1;
    chk("flush_in_ready", 64'(in_ready), 64'(0));
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < TAPS; i++) hist[i] = 0;
    chk("flush_not_accepted", 64'({pair_valid, in_ready}), 64'(1));
    do_sample(0, 0, 1'b0, 0, 1'b0, 0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
